// File: rtl/coin_change_dispenser_pkg.sv
// Shared coin codes, coin values and FSM state type for the coin change dispenser.
package coin_change_dispenser_pkg;

  localparam logic [1:0] COIN_05 = 2'b00;
  localparam logic [1:0] COIN_10 = 2'b01;
  localparam logic [1:0] COIN_50 = 2'b10;

  localparam logic [9:0] VAL_05  = 10'd5;
  localparam logic [9:0] VAL_10  = 10'd10;
  localparam logic [9:0] VAL_50  = 10'd50;
  localparam logic [9:0] BAL_MAX = 10'd999;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StReq,
    StDone,
    StFault
  } state_e;

  function automatic logic [9:0] coin_value(input logic [1:0] code);
    logic [9:0] val;
    case (code)
      COIN_05: val = VAL_05;
      COIN_10: val = VAL_10;
      COIN_50: val = VAL_50;
      default: val = 10'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_change_dispenser_coin_stock.sv
// Per-coin stock: three 8-bit saturating up/down counters indexed by coin code.
module coin_change_dispenser_coin_stock
  import coin_change_dispenser_pkg::*;
#(
  parameter int unsigned INIT_STOCK_50 = 20,
  parameter int unsigned INIT_STOCK_10 = 20,
  parameter int unsigned INIT_STOCK_5  = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dec_en_i,
  input  logic [1:0] dec_type_i,
  input  logic       inc_en_i,
  input  logic [1:0] inc_type_i,
  output logic [7:0] stock_50_o,
  output logic [7:0] stock_10_o,
  output logic [7:0] stock_5_o
);

  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      logic up, dn;
      up       = inc_en_i && (inc_type_i == 2'(i));
      dn       = dec_en_i && (dec_type_i == 2'(i));
      cnt_d[i] = cnt_q[i];
      if (up && !dn && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else if (dn && !up && (cnt_q[i] != 8'h00)) begin
        cnt_d[i] = cnt_q[i] - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q[COIN_05] <= 8'(INIT_STOCK_5);
      cnt_q[COIN_10] <= 8'(INIT_STOCK_10);
      cnt_q[COIN_50] <= 8'(INIT_STOCK_50);
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stock_5_o  = cnt_q[COIN_05];
  assign stock_10_o = cnt_q[COIN_10];
  assign stock_50_o = cnt_q[COIN_50];

endmodule

// File: rtl/coin_change_dispenser.sv
// Refund sequencer: pays a latched balance out largest-coin-first over a req/ack hopper handshake.
module coin_change_dispenser
  import coin_change_dispenser_pkg::*;
#(
  parameter int unsigned INIT_STOCK_50 = 20,
  parameter int unsigned INIT_STOCK_10 = 20,
  parameter int unsigned INIT_STOCK_5  = 20,
  parameter int unsigned ACK_TIMEOUT   = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       refund_start_i,
  input  logic [9:0] balance_in_i,
  input  logic       coin_ack_i,
  input  logic       restock_en_i,
  input  logic [1:0] restock_type_i,
  input  logic       fault_clr_i,
  output logic       coin_req_o,
  output logic [1:0] coin_type_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fault_o,
  output logic [9:0] remain_o,
  output logic [7:0] stock_50_o,
  output logic [7:0] stock_10_o,
  output logic [7:0] stock_5_o
);

  // The counter only needs to reach ACK_TIMEOUT-1: the fault is taken on that cycle's edge.
  localparam int unsigned TmoW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [9:0]      remain_q, remain_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [1:0]      coin_type_q, coin_type_d;
  logic            coin_req_q, busy_q, done_q, fault_q;
  logic            dec_en, inc_en;

  assign inc_en = restock_en_i && (state_q == StIdle) && (restock_type_i != 2'b11);

  coin_change_dispenser_coin_stock #(
    .INIT_STOCK_50(INIT_STOCK_50),
    .INIT_STOCK_10(INIT_STOCK_10),
    .INIT_STOCK_5 (INIT_STOCK_5)
  ) u_coin_stock (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .dec_en_i  (dec_en),
    .dec_type_i(coin_type_q),
    .inc_en_i  (inc_en),
    .inc_type_i(restock_type_i),
    .stock_50_o(stock_50_o),
    .stock_10_o(stock_10_o),
    .stock_5_o (stock_5_o)
  );

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    coin_type_d = coin_type_q;
    tmo_d       = '0;
    dec_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (refund_start_i) begin
          remain_d = (balance_in_i > BAL_MAX) ? BAL_MAX : balance_in_i;
          state_d  = StSelect;
        end
      end
      StSelect: begin
        if (remain_q == 10'd0) begin
          state_d = StDone;
        end else if ((remain_q >= VAL_50) && (stock_50_o != 8'd0)) begin
          coin_type_d = COIN_50;
          state_d     = StReq;
        end else if ((remain_q >= VAL_10) && (stock_10_o != 8'd0)) begin
          coin_type_d = COIN_10;
          state_d     = StReq;
        end else if ((remain_q >= VAL_05) && (stock_5_o != 8'd0)) begin
          coin_type_d = COIN_05;
          state_d     = StReq;
        end else begin
          state_d = StFault;
        end
      end
      StReq: begin
        if (coin_ack_i) begin
          remain_d = remain_q - coin_value(coin_type_q);
          dec_en   = 1'b1;
          state_d  = StSelect;
        end else if (tmo_q == TmoLast) begin
          state_d = StFault;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      StFault: begin
        if (fault_clr_i) begin
          remain_d = 10'd0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      remain_q    <= 10'd0;
      tmo_q       <= '0;
      coin_type_q <= COIN_05;
      coin_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      tmo_q       <= tmo_d;
      coin_type_q <= coin_type_d;
      coin_req_q  <= (state_d == StReq);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      fault_q     <= (state_d == StFault);
    end
  end

  assign coin_req_o  = coin_req_q;
  assign coin_type_o = coin_type_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign remain_o    = remain_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser with an in-bench hopper that acks one cycle after req.
module tb_coin_change_dispenser;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       refund_start_i;
  logic [9:0] balance_in_i;
  logic       coin_ack_i;
  logic       restock_en_i;
  logic [1:0] restock_type_i;
  logic       fault_clr_i;
  logic       coin_req_o;
  logic [1:0] coin_type_o;
  logic       busy_o;
  logic       done_o;
  logic       fault_o;
  logic [9:0] remain_o;
  logic [7:0] stock_50_o;
  logic [7:0] stock_10_o;
  logic [7:0] stock_5_o;

  int checks = 0;
  int passes = 0;

  logic [1:0] coin_q[$];
  logic [9:0] rem_q[$];
  int         done_cnt;
  int         status;
  int         k;

  coin_change_dispenser #(
    .INIT_STOCK_50(20),
    .INIT_STOCK_10(20),
    .INIT_STOCK_5 (20),
    .ACK_TIMEOUT  (1000)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .refund_start_i(refund_start_i),
    .balance_in_i  (balance_in_i),
    .coin_ack_i    (coin_ack_i),
    .restock_en_i  (restock_en_i),
    .restock_type_i(restock_type_i),
    .fault_clr_i   (fault_clr_i),
    .coin_req_o    (coin_req_o),
    .coin_type_o   (coin_type_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .fault_o       (fault_o),
    .remain_o      (remain_o),
    .stock_50_o    (stock_50_o),
    .stock_10_o    (stock_10_o),
    .stock_5_o     (stock_5_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  // status: 0 = done seen, 1 = fault seen, 2 = cycle budget expired
  task automatic run_refund(input logic [9:0] bal);
    logic prev_ack;
    coin_q.delete();
    rem_q.delete();
    done_cnt       = 0;
    status         = 2;
    prev_ack       = 1'b0;
    refund_start_i = 1'b1;
    balance_in_i   = bal;
    step();
    refund_start_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (prev_ack) rem_q.push_back(remain_o);
      if (done_o) begin
        done_cnt++;
        status = 0;
      end
      if (fault_o) status = 1;
      if (status != 2) break;
      if (coin_req_o && !coin_ack_i) begin
        coin_q.push_back(coin_type_o);
        coin_ack_i = 1'b1;
      end else begin
        coin_ack_i = 1'b0;
      end
      prev_ack = coin_ack_i;
      step();
    end
    coin_ack_i = 1'b0;
  endtask

  task automatic clear_fault();
    fault_clr_i = 1'b1;
    step();
    fault_clr_i = 1'b0;
    step();
  endtask

  initial begin
    rst_i          = 1'b1;
    refund_start_i = 1'b0;
    balance_in_i   = 10'd0;
    coin_ack_i     = 1'b0;
    restock_en_i   = 1'b0;
    restock_type_i = 2'b00;
    fault_clr_i    = 1'b0;
    do_reset();

    chk("rst_coin_req", 32'(coin_req_o), 0);
    chk("rst_coin_type", 32'(coin_type_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_fault", 32'(fault_o), 0);
    chk("rst_remain", 32'(remain_o), 0);
    chk("rst_stock_50", 32'(stock_50_o), 20);
    chk("rst_stock_10", 32'(stock_10_o), 20);
    chk("rst_stock_5", 32'(stock_5_o), 20);

    // 65 with full stock: 50, 10, 5
    run_refund(10'd65);
    chk("b65_status", 32'(status), 0);
    chk("b65_ncoins", 32'(coin_q.size()), 3);
    if (coin_q.size() == 3 && rem_q.size() == 3) begin
      chk("b65_coin0", 32'(coin_q[0]), 2);
      chk("b65_coin1", 32'(coin_q[1]), 1);
      chk("b65_coin2", 32'(coin_q[2]), 0);
      chk("b65_rem0", 32'(rem_q[0]), 15);
      chk("b65_rem1", 32'(rem_q[1]), 5);
      chk("b65_rem2", 32'(rem_q[2]), 0);
    end
    step();
    chk("b65_done_one_cycle", 32'(done_o), 0);
    chk("b65_busy_after", 32'(busy_o), 0);
    chk("b65_stock_50", 32'(stock_50_o), 19);
    chk("b65_stock_10", 32'(stock_10_o), 19);
    chk("b65_stock_5", 32'(stock_5_o), 19);

    // 1023 clamps to 999: 19x50, 4x10, 1x5, then 4 is unpayable
    run_refund(10'd1023);
    chk("clamp_status", 32'(status), 1);
    chk("clamp_ncoins", 32'(coin_q.size()), 24);
    chk("clamp_remain", 32'(remain_o), 4);
    chk("clamp_stock_50", 32'(stock_50_o), 0);
    chk("clamp_stock_10", 32'(stock_10_o), 15);
    chk("clamp_stock_5", 32'(stock_5_o), 18);
    clear_fault();
    chk("clamp_clr_fault", 32'(fault_o), 0);
    chk("clamp_clr_remain", 32'(remain_o), 0);
    chk("clamp_clr_busy", 32'(busy_o), 0);

    restock_en_i   = 1'b1;
    restock_type_i = 2'b01;
    repeat (5) step();
    restock_type_i = 2'b11;
    repeat (3) step();
    restock_en_i = 1'b0;
    step();
    chk("restock_stock_10", 32'(stock_10_o), 20);
    chk("restock11_stock_5", 32'(stock_5_o), 18);
    chk("restock11_stock_50", 32'(stock_50_o), 0);

    // 65 with no 50s: six 10s then one 5
    run_refund(10'd65);
    chk("no50_status", 32'(status), 0);
    chk("no50_ncoins", 32'(coin_q.size()), 7);
    if (coin_q.size() == 7) begin
      chk("no50_coin5", 32'(coin_q[5]), 1);
      chk("no50_coin6", 32'(coin_q[6]), 0);
    end
    step();
    chk("no50_stock_10", 32'(stock_10_o), 14);
    chk("no50_stock_5", 32'(stock_5_o), 17);

    run_refund(10'd140);
    step();
    chk("drain10_stock_10", 32'(stock_10_o), 0);
    run_refund(10'd80);
    step();
    chk("drain5_stock_5", 32'(stock_5_o), 1);

    // 15 with only one 5 left
    run_refund(10'd15);
    chk("short_status", 32'(status), 1);
    chk("short_ncoins", 32'(coin_q.size()), 1);
    chk("short_remain", 32'(remain_o), 10);
    clear_fault();
    chk("short_clr_remain", 32'(remain_o), 0);
    chk("short_clr_busy", 32'(busy_o), 0);

    // Timeout, with restock and refund_start attempted while busy
    do_reset();
    refund_start_i = 1'b1;
    balance_in_i   = 10'd50;
    step();
    refund_start_i = 1'b0;
    chk("start_busy_n1", 32'(busy_o), 1);
    chk("start_req_n1", 32'(coin_req_o), 0);
    step();
    chk("start_req_n2", 32'(coin_req_o), 1);
    chk("start_type_n2", 32'(coin_type_o), 2);
    k = 0;
    while (!fault_o && k < 1100) begin
      if (k == 2) begin
        restock_en_i   = 1'b1;
        restock_type_i = 2'b10;
        refund_start_i = 1'b1;
        balance_in_i   = 10'd7;
      end else begin
        restock_en_i   = 1'b0;
        refund_start_i = 1'b0;
      end
      step();
      k++;
    end
    restock_en_i   = 1'b0;
    refund_start_i = 1'b0;
    chk("tmo_cycles", 32'(k), 1000);
    chk("tmo_remain", 32'(remain_o), 50);
    chk("tmo_stock_50", 32'(stock_50_o), 20);
    chk("tmo_req_low", 32'(coin_req_o), 0);
    clear_fault();
    chk("tmo_clr_fault", 32'(fault_o), 0);

    // Reset while a coin request is outstanding
    refund_start_i = 1'b1;
    balance_in_i   = 10'd50;
    step();
    refund_start_i = 1'b0;
    for (int c = 0; c < 20 && !coin_req_o; c++) step();
    chk("rstreq_req_seen", 32'(coin_req_o), 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rstreq_coin_req", 32'(coin_req_o), 0);
    chk("rstreq_busy", 32'(busy_o), 0);
    chk("rstreq_stock_50", 32'(stock_50_o), 20);
    run_refund(10'd10);
    chk("rstreq_after_status", 32'(status), 0);
    chk("rstreq_after_ncoins", 32'(coin_q.size()), 1);
    step();
    chk("rstreq_after_stock_10", 32'(stock_10_o), 19);

    restock_en_i   = 1'b1;
    restock_type_i = 2'b01;
    repeat (240) step();
    restock_en_i = 1'b0;
    step();
    chk("sat_stock_10", 32'(stock_10_o), 255);

    run_refund(10'd0);
    chk("zero_status", 32'(status), 0);
    chk("zero_ncoins", 32'(coin_q.size()), 0);
    step();
    chk("zero_busy_after", 32'(busy_o), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
